// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command parser: ASCII codes, FSM states and
// response selection/length/byte lookup.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_QM = 8'h3F;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_EXEC    = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;

  typedef enum logic [1:0] {
    RSP_OK  = 2'd0,
    RSP_ERR = 2'd1,
    RSP_QRY = 2'd2
  } rsp_sel_e;

  localparam logic [2:0] RSP_OK_LEN  = 3'd4;
  localparam logic [2:0] RSP_ERR_LEN = 3'd3;
  localparam logic [2:0] RSP_QRY_LEN = 3'd4;

  function automatic logic [2:0] rsp_len(input rsp_sel_e sel);
    case (sel)
      RSP_OK:  rsp_len = RSP_OK_LEN;
      RSP_ERR: rsp_len = RSP_ERR_LEN;
      RSP_QRY: rsp_len = RSP_QRY_LEN;
      default: rsp_len = RSP_ERR_LEN;
    endcase
  endfunction

  // Every response ends in CR LF; only the leading bytes differ per kind.
  function automatic logic [7:0] rsp_byte(input rsp_sel_e sel, input logic [1:0] idx,
                                          input logic [7:0] qry_chr);
    logic [7:0] b0;
    logic [7:0] b1;
    b0 = ASCII_E;
    b1 = ASCII_CR;
    case (sel)
      RSP_OK: begin
        b0 = ASCII_O;
        b1 = ASCII_K;
      end
      RSP_QRY: begin
        b0 = ASCII_L;
        b1 = qry_chr;
      end
      default: begin
        b0 = ASCII_E;
        b1 = ASCII_CR;
      end
    endcase
    if (sel == RSP_ERR) begin
      case (idx)
        2'd0:    rsp_byte = b0;
        2'd1:    rsp_byte = ASCII_CR;
        default: rsp_byte = ASCII_LF;
      endcase
    end else begin
      case (idx)
        2'd0:    rsp_byte = b0;
        2'd1:    rsp_byte = b1;
        2'd2:    rsp_byte = ASCII_CR;
        default: rsp_byte = ASCII_LF;
      endcase
    end
  endfunction

endpackage

// File: rtl/uart_cmd_hex_conv.sv
// Combinational hex helpers: ASCII hex digit to nibble (with valid flag) and
// nibble to uppercase ASCII hex.
module uart_cmd_hex_conv (
  input  logic [7:0] ascii_i,
  output logic [3:0] nibble_o,
  output logic       nibble_vld_o,
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    nibble_o     = 4'd0;
    nibble_vld_o = 1'b0;
    if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
      nibble_o     = ascii_i[3:0];
      nibble_vld_o = 1'b1;
    end else if ((ascii_i >= 8'h41 && ascii_i <= 8'h46) ||
                 (ascii_i >= 8'h61 && ascii_i <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 lands on 10.
      nibble_o     = ascii_i[3:0] + 4'd9;
      nibble_vld_o = 1'b1;
    end
  end

  always_comb begin
    if (nibble_i < 4'd10) begin
      ascii_o = 8'h30 + {4'd0, nibble_i};
    end else begin
      ascii_o = 8'h37 + {4'd0, nibble_i};
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles CR/LF-terminated ASCII lines from rx strobes, executes LED set/query
// commands and streams the reply on tx valid/ready; optional idle timeout via UART_CMD_TIMEOUT_EN.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN        = 8,
  parameter int TIMEOUT_CYCLES = 33000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic [2:0] led,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    line_q [MAX_LEN];
  logic [7:0]    line_d [MAX_LEN];
  logic [2:0]    led_q, led_d;
  rsp_sel_e      rsp_sel_q, rsp_sel_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    qry_chr_q, qry_chr_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          cmd_done_q, cmd_done_d;
  logic          cmd_err_q, cmd_err_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic [3:0]    hex_nib;
  logic          hex_vld;
  logic [7:0]    led_chr;
  logic          hex_nib_unused;
  logic          rx_is_term;

  assign busy           = (state_q != S_COLLECT);
  assign rx_is_term     = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
  assign hex_nib_unused = hex_nib[3];

  uart_cmd_hex_conv u_hex_conv (
    .ascii_i      (line_q[1]),
    .nibble_o     (hex_nib),
    .nibble_vld_o (hex_vld),
    .nibble_i     ({1'b0, led_q}),
    .ascii_o      (led_chr)
  );

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  localparam int tmo_unused = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    line_d     = line_q;
    led_d      = led_q;
    rsp_sel_d  = rsp_sel_q;
    idx_d      = idx_q;
    qry_chr_d  = qry_chr_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    cmd_done_d = 1'b0;
    cmd_err_d  = 1'b0;
    drop_cnt_d = drop_cnt_q;

    if (rx_valid && busy && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    case (state_q)
      S_COLLECT: begin
        if (rx_valid) begin
          if (rx_is_term) begin
            // Bare terminators swallow the second half of CRLF and blank lines.
            if (len_q != '0) begin
              state_d = S_EXEC;
            end
          end else if (len_q < MAX_LEN_L) begin
            line_d[len_q[IW-1:0]] = rx_data;
            len_d                 = len_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      S_EXEC: begin
        cmd_done_d = 1'b1;
        if (ovf_q) begin
          rsp_sel_d = RSP_ERR;
          cmd_err_d = 1'b1;
        end else if (len_q == LW'(2) && line_q[0] == ASCII_L && hex_vld) begin
          led_d     = hex_nib[2:0];
          rsp_sel_d = RSP_OK;
        end else if (len_q == LW'(1) && line_q[0] == ASCII_QM) begin
          rsp_sel_d = RSP_QRY;
          qry_chr_d = led_chr;
        end else begin
          rsp_sel_d = RSP_ERR;
          cmd_err_d = 1'b1;
        end
        idx_d      = 2'd0;
        tx_valid_d = 1'b1;
        tx_data_d  = rsp_byte(rsp_sel_d, 2'd0, qry_chr_d);
        state_d    = S_RESP;
      end

      S_RESP: begin
        if (tx_valid_q && tx_ready) begin
          if ({1'b0, idx_q} == rsp_len(rsp_sel_q) - 3'd1) begin
            tx_valid_d = 1'b0;
            len_d      = '0;
            ovf_d      = 1'b0;
            state_d    = S_COLLECT;
          end else begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = rsp_byte(rsp_sel_q, idx_d, qry_chr_q);
          end
        end
      end

      default: state_d = S_COLLECT;
    endcase

`ifdef UART_CMD_TIMEOUT_EN
    // Idle counter only runs while a partial line is pending.
    tmo_d = '0;
    if (state_q == S_COLLECT && !rx_valid && (len_q != '0 || ovf_q)) begin
      if (tmo_q == TMO_LAST) begin
        len_d = '0;
        ovf_d = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_COLLECT;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      led_q      <= 3'd0;
      rsp_sel_q  <= RSP_OK;
      idx_q      <= 2'd0;
      qry_chr_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'd0;
      cmd_done_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      led_q      <= led_d;
      rsp_sel_q  <= rsp_sel_d;
      idx_q      <= idx_d;
      qry_chr_q  <= qry_chr_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cmd_done_q <= cmd_done_d;
      cmd_err_q  <= cmd_err_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Line storage is qualified by len_q, so it needs no reset.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign led      = led_q;
  assign cmd_done = cmd_done_q;
  assign cmd_err  = cmd_err_q;
  assign drop_cnt = drop_cnt_q;

endmodule
